// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// FSM state encoding, PC field positions and storage widths.
package icache_pkg;

    localparam int NUM_BLOCKS      = 8;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_BITS      = 128;
    localparam int TAG_BITS        = 3;
    localparam int INDEX_BITS      = 3;
    localparam int LINE_ADDR_BITS  = TAG_BITS + INDEX_BITS;

    // PC field positions: [3:2] word offset, [6:4] index, [9:7] tag.
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;
    localparam int TAG_LSB    = 7;
    localparam int TAG_MSB    = 9;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_e;

    // Block address {tag,index} of the line holding a given PC.
    function automatic logic [LINE_ADDR_BITS-1:0] line_addr(input logic [31:0] pc);
        return pc[TAG_MSB:INDEX_LSB];
    endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-port and memory-port bundle of the instruction cache.
//
// Handshake: the CPU presents PC and takes INSTRUCTION in any cycle where
// BUSYWAIT=0; while BUSYWAIT=1 it holds PC. Towards memory the cache raises
// MEM_READ with a stable MEM_ADDRESS until the memory drops MEM_BUSYWAIT; the
// cycle in which MEM_READ=1 and MEM_BUSYWAIT=0 carries valid MEM_READDATA.
interface icache_if;
    import icache_pkg::*;

    logic [31:0]             PC;
    logic [31:0]             INSTRUCTION;
    logic                    BUSYWAIT;
    logic                    MEM_READ;
    logic [LINE_ADDR_BITS-1:0] MEM_ADDRESS;
    logic [BLOCK_BITS-1:0]   MEM_READDATA;
    logic                    MEM_BUSYWAIT;

    // Cache side.
    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    // CPU + memory side.
    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

endinterface

// File: rtl/icache_refill_fsm.sv
// Miss/refill sequencer: holds the miss address, drives the memory request
// and the CPU stall, and tells the storage when to capture a refill block.
module icache_refill_fsm
    import icache_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      hit_i,
    input  logic [LINE_ADDR_BITS-1:0] lookup_addr_i,
    input  logic                      mem_busywait_i,
    output logic                      mem_read_o,
    output logic [LINE_ADDR_BITS-1:0] mem_address_o,
    output logic                      busywait_o,
    output logic                      refill_we_o,
    output state_e                    state_o
);

    state_e                    state_q, state_d;
    logic [LINE_ADDR_BITS-1:0] miss_q, miss_d;

    // State and miss-address registers; reset aborts any refill in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // Next state, miss latch and request/stall outputs.
    always_comb begin
        state_d     = state_q;
        miss_d      = miss_q;
        mem_read_o  = 1'b0;
        busywait_o  = 1'b0;
        refill_we_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit_i) begin
                    busywait_o = 1'b1;
                    miss_d     = lookup_addr_i;
                    state_d    = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                busywait_o = 1'b1;
                if (!mem_busywait_i) begin
                    refill_we_o = 1'b1;
                    state_d     = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busywait_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // While reset is held the CPU is never stalled and no line is written.
        if (!rst_ni) begin
            busywait_o  = 1'b0;
            refill_we_o = 1'b0;
        end
    end

    // MEM_ADDRESS is the miss register itself, so it holds between refills.
    assign mem_address_o = miss_q;
    assign state_o       = state_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: 8 lines of 4 words, same-cycle hits,
// block refill from a slow instruction memory on a miss.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic     CLK,
    input  logic     RESET,
    icache_if.slave  bus,
    output state_e   dbg_state_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
    logic [BLOCK_BITS-1:0] data_q [NUM_BLOCKS];

    logic [INDEX_BITS-1:0]     lookup_idx;
    logic [TAG_BITS-1:0]       lookup_tag;
    logic [1:0]                lookup_off;
    logic                      hit;
    logic                      refill_we;
    logic [INDEX_BITS-1:0]     refill_idx;
    logic [TAG_BITS-1:0]       refill_tag;
    logic                      unused_pc_bits;

    assign lookup_idx     = bus.PC[TAG_LSB-1:INDEX_LSB];
    assign lookup_tag     = bus.PC[TAG_MSB:TAG_LSB];
    assign lookup_off     = bus.PC[INDEX_LSB-1:OFFSET_LSB];
    assign unused_pc_bits = ^{bus.PC[31:TAG_MSB+1], bus.PC[OFFSET_LSB-1:0]};

    assign refill_idx = bus.MEM_ADDRESS[INDEX_BITS-1:0];
    assign refill_tag = bus.MEM_ADDRESS[LINE_ADDR_BITS-1:INDEX_BITS];

    // Lookup; a non-hit returns 0 so never-written data cannot leak out as X.
    always_comb begin
        hit             = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        bus.INSTRUCTION = '0;
        if (hit) begin
            bus.INSTRUCTION = data_q[lookup_idx][{lookup_off, 5'd0} +: 32];
        end
    end

    icache_refill_fsm u_refill_fsm (
        .clk_i          (CLK),
        .rst_ni         (RESET),
        .hit_i          (hit),
        .lookup_addr_i  (line_addr(bus.PC)),
        .mem_busywait_i (bus.MEM_BUSYWAIT),
        .mem_read_o     (bus.MEM_READ),
        .mem_address_o  (bus.MEM_ADDRESS),
        .busywait_o     (bus.BUSYWAIT),
        .refill_we_o    (refill_we),
        .state_o        (dbg_state_o)
    );

    // Valid bits: cleared by reset, set when a refill block lands.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (refill_we) begin
            valid_q[refill_idx] <= 1'b1;
        end
    end

    // Tag and data capture on the refill cycle; contents survive reset.
    always_ff @(posedge CLK) begin
        if (refill_we) begin
            tag_q[refill_idx]  <= refill_tag;
            data_q[refill_idx] <= bus.MEM_READDATA;
        end
    end

endmodule
